clk_div_ce_multi: RTL and testbench



---
 rtl/clk_div_ce_multi.sv | 66 ++++++
 tb/tb_clk_div_ce_multi.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ce_multi.sv
// Multi-channel programmable clock-enable generator: each channel pulses ce every
// active+1 clocks and toggles tgl on each pulse; divide values reload at terminal count.
module clk_div_ce_multi #(
  parameter int NCHAN       = 4,
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 31
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [3:0]           wr_chan,
  input  logic [DIV_WIDTH-1:0] wr_div,
  input  logic                 sync,
  input  logic [NCHAN-1:0]     en,
  output logic [NCHAN-1:0]     ce,
  output logic [NCHAN-1:0]     tgl
);

  localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);

  logic [DIV_WIDTH-1:0] cnt    [NCHAN];
  logic [DIV_WIDTH-1:0] shadow [NCHAN];
  logic [DIV_WIDTH-1:0] active [NCHAN];
  logic                 unused_active;

  // Shadow writes land with non-blocking semantics, so a reload on the same
  // edge always picks up the previous shadow value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCHAN; i++) begin
        cnt[i]    <= DEF_DIV;
        shadow[i] <= DEF_DIV;
        active[i] <= DEF_DIV;
        ce[i]     <= 1'b0;
        tgl[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        if (wr_en && (wr_chan == 4'(i)))
          shadow[i] <= wr_div;

        if (!en[i] || sync) begin
          cnt[i]    <= shadow[i];
          active[i] <= shadow[i];
          ce[i]     <= 1'b0;
        end else if (cnt[i] == '0) begin
          cnt[i]    <= shadow[i];
          active[i] <= shadow[i];
          ce[i]     <= 1'b1;
          tgl[i]    <= ~tgl[i];
        end else begin
          cnt[i] <= cnt[i] - 1'b1;
          ce[i]  <= 1'b0;
        end
      end
    end
  end

  // active[] records the period in force for debug visibility only.
  always_comb begin
    unused_active = 1'b0;
    for (int i = 0; i < NCHAN; i++)
      unused_active = unused_active ^ (^active[i]);
  end

endmodule

// File: tb/tb_clk_div_ce_multi.sv
// Randomized bench for clk_div_ce_multi, checked against a timestamp-based model:
// each channel remembers its last reload edge and pulses when the period has elapsed.
module tb_clk_div_ce_multi;

  localparam int NCHAN = 4;
  localparam int DW    = 8;
  localparam int DEF   = 31;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [3:0]    wr_chan;
  logic [DW-1:0] wr_div;
  logic          sync;
  logic [NCHAN-1:0] en;
  logic [NCHAN-1:0] ce;
  logic [NCHAN-1:0] tgl;

  clk_div_ce_multi #(.NCHAN(NCHAN), .DIV_WIDTH(DW), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_chan(wr_chan), .wr_div(wr_div),
    .sync(sync), .en(en), .ce(ce), .tgl(tgl)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int t = 0;
  int last_rl  [NCHAN];
  int per_s    [NCHAN];
  int m_shadow [NCHAN];
  logic [NCHAN-1:0] m_ce  = '0;
  logic [NCHAN-1:0] m_tgl = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%h want=%h", tag, t, obs, exp);
    end
  endtask

  // A channel pulses when S+1 edges have passed since its last reload.
  task automatic model_edge();
    t++;
    if (!rst_n) begin
      for (int i = 0; i < NCHAN; i++) begin
        m_shadow[i] = DEF;
        per_s[i]    = DEF;
        last_rl[i]  = t;
      end
      m_ce  = '0;
      m_tgl = '0;
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        if (!en[i] || sync) begin
          m_ce[i]    = 1'b0;
          last_rl[i] = t;
          per_s[i]   = m_shadow[i];
        end else if (t - last_rl[i] == per_s[i] + 1) begin
          m_ce[i]    = 1'b1;
          m_tgl[i]   = ~m_tgl[i];
          last_rl[i] = t;
          per_s[i]   = m_shadow[i];
        end else begin
          m_ce[i] = 1'b0;
        end
      end
      if (wr_en && int'(wr_chan) < NCHAN)
        m_shadow[wr_chan] = int'(wr_div);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("ce", 32'(ce), 32'(m_ce));
    chk("tgl", 32'(tgl), 32'(m_tgl));
    wr_en = 1'b0;
    sync  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic write(input int ch, input int dv);
    wr_en   = 1'b1;
    wr_chan = 4'(ch);
    wr_div  = DW'(dv);
    cycle();
  endtask

  int pulses;
  int waited;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_chan = '0; wr_div = '0; sync = 1'b0; en = '1;
    run(3);
    chk("rst_ce", 32'(ce), 32'd0);
    chk("rst_tgl", 32'(tgl), 32'd0);

    // default period: pulses after E31, E63, E95
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (ce[0]) pulses++;
    end
    chk("def_pulses", 32'(pulses), 32'd3);

    write(1, 3);
    run(80);
    write(2, 0);
    run(40);
    write(15, 5);
    run(40);

    write(0, 4);
    write(3, 9);
    run(3);
    sync = 1'b1;
    cycle();
    chk("sync_ce", 32'(ce & 4'b1001), 32'd0);
    run(60);

    en[1] = 1'b0;
    run(7);
    en[1] = 1'b1;
    run(40);

    // write landing exactly on ch1's terminal-count edge
    waited = 0;
    while ((t + 1 - last_rl[1] != per_s[1] + 1) && waited < 300) begin
      cycle();
      waited++;
    end
    chk("tc_wait", 32'(waited < 300), 32'd1);
    write(1, 6);
    run(30);

    rst_n = 1'b0;
    cycle();
    chk("mid_rst_ce", 32'(ce), 32'd0);
    chk("mid_rst_tgl", 32'(tgl), 32'd0);
    rst_n = 1'b1;
    run(70);

    // longest period reachable with an 8-bit divide
    write(0, 255);
    sync = 1'b1;
    cycle();
    pulses = 0;
    for (int k = 0; k < 260; k++) begin
      cycle();
      if (ce[0]) pulses++;
    end
    chk("max_div_pulses", 32'(pulses), 32'd1);

    for (int k = 0; k < 4000; k++) begin
      rst_n = ($urandom % 300) != 0;
      for (int i = 0; i < NCHAN; i++) en[i] = ($urandom % 20) != 0;
      sync    = ($urandom % 60) == 0;
      wr_en   = ($urandom % 8) == 0;
      wr_chan = 4'($urandom % 16);
      case ($urandom % 8)
        0:       wr_div = DW'($urandom);
        1:       wr_div = '0;
        default: wr_div = DW'($urandom % 13);
      endcase
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
